// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: bundles the display-word load path, the digit enable mask and the
// scan outputs of seg_scan_mux.
//   master : drives load, data_in, digit_en; observes hex, anodes, frame_done, pending
//   slave  : the scan controller side (the reverse directions)
interface seg_scan_mux_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic                    load;        // one-cycle strobe: capture data_in
  logic [4*NUM_DIGITS-1:0] data_in;     // digit i = data_in[4i+3:4i], digit 0 rightmost
  logic [NUM_DIGITS-1:0]   digit_en;    // per-digit enable, 0 = dark
  logic [3:0]              hex;         // nibble for the hex-to-7-segment decoder
  logic [NUM_DIGITS-1:0]   anodes;      // active-low digit enables, one-hot-low
  logic                    frame_done;  // pulse after the last digit's slot
  logic                    pending;     // loaded word waiting for the frame boundary

  modport master (
    output load, data_in, digit_en,
    input  hex, anodes, frame_done, pending
  );

  modport slave (
    input  load, data_in, digit_en,
    output hex, anodes, frame_done, pending
  );
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed scan controller for a multi-digit 7-segment display.
// Holds a NUM_DIGITS-nibble display word, lights one digit per refresh slot through
// active-low anodes and presents that digit's nibble on hex. New words are staged in a
// shadow register and applied only at the frame boundary, so a frame is never torn.
//
// Ports:
//   i_clk    : system clock, all state on the rising edge
//   i_reset  : synchronous, active-high reset
//   io_bus   : seg_scan_mux_if slave (load, data_in, digit_en in;
//              hex, anodes, frame_done, pending out)
//
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading zero digits
// (digit 0 is never blanked).
module seg_scan_mux #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 17
) (
  input logic          i_clk,
  input logic          i_reset,
  seg_scan_mux_if.slave io_bus
);

  localparam int unsigned IdxW  = $clog2(NUM_DIGITS);
  localparam int unsigned WordW = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      r_cnt;
  logic [IdxW-1:0]       r_idx;
  logic [WordW-1:0]      r_disp;
  logic [WordW-1:0]      r_shadow;
  logic                  r_pending;
  logic [3:0]            r_hex;
  logic [NUM_DIGITS-1:0] r_anodes;
  logic                  r_frame_done;

  logic [CNT_W-1:0]      w_cnt_d;
  logic [IdxW-1:0]       w_idx_d;
  logic [WordW-1:0]      w_disp_d;
  logic [WordW-1:0]      w_shadow_d;
  logic                  w_pending_d;
  logic [3:0]            w_hex_d;
  logic [NUM_DIGITS-1:0] w_anodes_d;

  logic                  w_cnt_end;
  logic                  w_wrap;
  logic [3:0]            w_nibble;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_blank;

  // Leading-zero blank mask, derived purely from the applied display word.
`ifdef LEADING_ZERO_BLANK_EN
  logic w_hi_zero;
  always_comb begin
    w_blank   = '0;
    w_hi_zero = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      w_hi_zero  = w_hi_zero && (r_disp[4*i +: 4] == 4'h0);
      w_blank[i] = w_hi_zero;
    end
  end
`else
  assign w_blank = '0;
`endif

  // Refresh timing and word staging.
  always_comb begin
    w_cnt_end   = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    w_wrap      = w_cnt_end && (r_idx == IdxW'(NUM_DIGITS - 1));
    w_cnt_d     = w_cnt_end ? '0 : r_cnt + CNT_W'(1);
    w_idx_d     = r_idx;
    w_disp_d    = r_disp;
    w_shadow_d  = r_shadow;
    w_pending_d = r_pending;

    if (w_cnt_end) begin
      w_idx_d = w_wrap ? '0 : r_idx + IdxW'(1);
    end

    if (w_wrap) begin
      // A load landing on the wrap cycle bypasses the shadow and shows next frame.
      if (io_bus.load) begin
        w_disp_d = io_bus.data_in;
      end else if (r_pending) begin
        w_disp_d = r_shadow;
      end
      w_pending_d = 1'b0;
    end else if (io_bus.load) begin
      w_shadow_d  = io_bus.data_in;
      w_pending_d = 1'b1;
    end
  end

  // Output stage: digit selected by the current index, registered one cycle later.
  always_comb begin
    w_nibble = r_disp[{r_idx, 2'b00} +: 4];
    w_lit    = io_bus.digit_en[r_idx] && !w_blank[r_idx];
    w_hex_d  = w_blank[r_idx] ? 4'h0 : w_nibble;
    w_anodes_d = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      w_anodes_d[i] = !(w_lit && (r_idx == IdxW'(i)));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_disp       <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_hex        <= 4'h0;
      r_anodes     <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_d;
      r_idx        <= w_idx_d;
      r_disp       <= w_disp_d;
      r_shadow     <= w_shadow_d;
      r_pending    <= w_pending_d;
      r_hex        <= w_hex_d;
      r_anodes     <= w_anodes_d;
      r_frame_done <= w_wrap;
    end
  end

  assign io_bus.hex        = r_hex;
  assign io_bus.anodes     = r_anodes;
  assign io_bus.frame_done = r_frame_done;
  assign io_bus.pending    = r_pending;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed bench for seg_scan_mux (NUM_DIGITS=4, REFRESH_DIV=4).
// Expected {anodes, hex, frame_done} per cycle are queued when a frame's word and
// enable mask are known and popped one per clock as the DUT scans.
module tb_seg_scan_mux;

  localparam int unsigned ND = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [8:0] q[$];

  seg_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(4),
    .CNT_W      (2)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue one whole frame of expected outputs for a given applied word and enable mask.
  task automatic push_frame(input logic [15:0] word, input logic [3:0] en);
    logic [3:0] an;
    logic [3:0] hx;
    logic       blank;
    logic       lit;
    for (int d = 0; d < 4; d++) begin
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = (d > 0) && ((word >> (4 * d)) == 16'h0);
`endif
      lit = en[d] && !blank;
      an  = lit ? ~(4'b0001 << d) : 4'b1111;
      hx  = blank ? 4'h0 : word[4*d +: 4];
      for (int c = 0; c < 4; c++) begin
        q.push_back({an, hx, (d == 3) && (c == 3)});
      end
    end
  endtask

  task automatic push_reset(input int n);
    for (int i = 0; i < n; i++) q.push_back({4'b1111, 4'h0, 1'b0});
  endtask

  // One clock: let the edge happen, then compare outputs at the falling edge.
  task automatic tick();
    logic [8:0] exp;
    logic [8:0] obs;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h required=entry", {bus.anodes, bus.hex,
             bus.frame_done});
    end else begin
      exp = q.pop_front();
      obs = {bus.anodes, bus.hex, bus.frame_done};
      assert (obs === exp) else begin
        errors++;
        $error("FAIL scan t=%0t observed an=%b hex=%h fd=%b required an=%b hex=%h fd=%b",
               $time, obs[8:5], obs[4:1], obs[0], exp[8:5], exp[4:1], exp[0]);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_pending(input string tag, input logic want);
    checks++;
    assert (bus.pending === want) else begin
      errors++;
      $error("FAIL %s observed pending=%b required pending=%b", tag, bus.pending, want);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.load     = 1'b0;
    bus.data_in  = 16'h0;
    bus.digit_en = 4'b1111;

    // Reset held three cycles.
    push_reset(3);
    ticks(3);
    check_pending("reset_pending", 1'b0);
    reset = 1'b0;

    // Frame 0: word 0; BEEF loaded mid-frame and held back until the wrap.
    push_frame(16'h0000, 4'b1111);
    ticks(5);
    bus.load    = 1'b1;
    bus.data_in = 16'hBEEF;
    tick();
    bus.load    = 1'b0;
    bus.data_in = 16'hDEAD;
    check_pending("beef_pending", 1'b1);
    ticks(10);
    check_pending("beef_applied", 1'b0);

    // Frame 1: BEEF; load 1234 exactly on the wrap cycle.
    push_frame(16'hBEEF, 4'b1111);
    ticks(15);
    bus.load    = 1'b1;
    bus.data_in = 16'h1234;
    tick();
    bus.load    = 1'b0;
    check_pending("wrap_load_pending", 1'b0);

    // Frame 2: 1234; two loads, the last one wins.
    push_frame(16'h1234, 4'b1111);
    ticks(2);
    bus.load    = 1'b1;
    bus.data_in = 16'h1111;
    tick();
    bus.load    = 1'b0;
    ticks(5);
    bus.load    = 1'b1;
    bus.data_in = 16'h2222;
    tick();
    bus.load    = 1'b0;
    check_pending("two_loads_pending", 1'b1);
    ticks(7);
    check_pending("two_loads_applied", 1'b0);

    // Frames 3-4: 2222 with digit 2 disabled.
    bus.digit_en = 4'b1011;
    push_frame(16'h2222, 4'b1011);
    ticks(16);
    push_frame(16'h2222, 4'b1011);
    ticks(3);
    bus.load    = 1'b1;
    bus.data_in = 16'h5555;
    tick();
    bus.load    = 1'b0;
    check_pending("pre_reset_pending", 1'b1);
    ticks(2);

    // Reset mid-frame drops the pending word and clears the display word.
    q.delete();
    push_reset(2);
    reset = 1'b1;
    ticks(2);
    check_pending("mid_reset_pending", 1'b0);
    reset        = 1'b0;
    bus.digit_en = 4'b1111;

    push_frame(16'h0000, 4'b1111);
    ticks(15);
    bus.load    = 1'b1;
    bus.data_in = 16'h0050;
    tick();
    bus.load    = 1'b0;

    push_frame(16'h0050, 4'b1111);
    ticks(15);
    bus.load    = 1'b1;
    bus.data_in = 16'h0000;
    tick();
    bus.load    = 1'b0;

    push_frame(16'h0000, 4'b1111);
    ticks(16);
    check_pending("final_pending", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
